// File: rtl/axis_frame_rr_arbiter.sv
// Frame-aware round-robin arbiter: S_COUNT AXI4-Stream inputs share one registered output.
// A grant is held from the first beat of a frame until its tlast is accepted.
module axis_frame_rr_arbiter #(
   parameter int S_COUNT     = 4,
   parameter int DATA_WIDTH  = 8,
   parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
   parameter bit LAST_ENABLE = 1,
   parameter bit USER_ENABLE = 1,
   parameter int USER_WIDTH  = 1,
   parameter int CL_S_COUNT  = (S_COUNT > 1) ? $clog2(S_COUNT) : 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [S_COUNT*KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic [S_COUNT-1:0]            s_axis_tvalid,
   output logic [S_COUNT-1:0]            s_axis_tready,
   input  logic [S_COUNT-1:0]            s_axis_tlast,
   input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast,
   output logic [USER_WIDTH-1:0]         m_axis_tuser,
   output logic                          grant_valid,
   output logic [CL_S_COUNT-1:0]         grant_index
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] XFER = 1'b1;

   logic [0:0]            state;
   logic [CL_S_COUNT-1:0] gidx;
   logic [CL_S_COUNT-1:0] last_grant;
   logic [CL_S_COUNT-1:0] pick;
   logic                  pick_found;

   logic [DATA_WIDTH-1:0] data_reg;
   logic [KEEP_WIDTH-1:0] keep_reg;
   logic                  last_reg;
   logic [USER_WIDTH-1:0] user_reg;
   logic                  valid_reg;

   logic                  slot_free;
   logic                  accept;
   logic                  frame_end;
   logic [DATA_WIDTH-1:0] sel_data;
   logic [KEEP_WIDTH-1:0] sel_keep;
   logic [USER_WIDTH-1:0] sel_user;
   logic                  sel_last;
   logic                  sel_valid;

   assign slot_free = m_axis_tready || !valid_reg;

   assign sel_data  = s_axis_tdata[gidx*DATA_WIDTH +: DATA_WIDTH];
   assign sel_keep  = s_axis_tkeep[gidx*KEEP_WIDTH +: KEEP_WIDTH];
   assign sel_user  = s_axis_tuser[gidx*USER_WIDTH +: USER_WIDTH];
   assign sel_last  = s_axis_tlast[gidx];
   assign sel_valid = s_axis_tvalid[gidx];

   assign accept    = (state == XFER) && sel_valid && slot_free;
   assign frame_end = accept && (sel_last || !LAST_ENABLE);

   // Ready depends only on registered state, so there is no request-to-ready path.
   always_comb begin
      s_axis_tready = '0;
      if (state == XFER) s_axis_tready[gidx] = slot_free;
   end

   // Scan downward so the nearest requester after last_grant wins.
   always_comb begin
      pick       = last_grant;
      pick_found = 1'b0;
      for (int k = S_COUNT; k >= 1; k--) begin
         if (s_axis_tvalid[(int'(last_grant) + k) % S_COUNT]) begin
            pick       = CL_S_COUNT'((int'(last_grant) + k) % S_COUNT);
            pick_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         gidx       <= '0;
         last_grant <= CL_S_COUNT'(S_COUNT - 1);
         valid_reg  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_found) begin
                  gidx       <= pick;
                  last_grant <= pick;
                  state      <= XFER;
               end
            end
            XFER: begin
               if (frame_end) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (accept)             valid_reg <= 1'b1;
         else if (m_axis_tready) valid_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         data_reg <= sel_data;
         keep_reg <= sel_keep;
         last_reg <= sel_last;
         user_reg <= sel_user;
      end
   end

   assign m_axis_tdata  = data_reg;
   assign m_axis_tkeep  = KEEP_ENABLE ? keep_reg : '1;
   assign m_axis_tlast  = LAST_ENABLE ? last_reg : 1'b1;
   assign m_axis_tuser  = USER_ENABLE ? user_reg : '0;
   assign m_axis_tvalid = valid_reg;
   assign grant_valid   = (state == XFER);
   assign grant_index   = gidx;

endmodule

// File: doc/axis_frame_rr_arbiter.md
Name: axis_frame_rr_arbiter

Overview:
- Frame-aware round-robin arbiter that multiplexes S_COUNT AXI4-Stream inputs onto one output stream.
- Typically sits in front of an axis_fifo instance so several producers share one buffer.
- Grant is held for a whole frame (until tlast) so frames never interleave.
- Output is registered; per-input tready is gated by the current grant.

Parameters:
S_COUNT, 4, number of input streams (2..16)
DATA_WIDTH, 8, tdata width per stream
KEEP_ENABLE, (DATA_WIDTH>8), carry tkeep
KEEP_WIDTH, (DATA_WIDTH/8), tkeep width
LAST_ENABLE, 1, carry tlast; when 0 every beat is a one-beat frame
USER_ENABLE, 1, carry tuser
USER_WIDTH, 1, tuser width
CL_S_COUNT, $clog2(S_COUNT), grant index width (min 1)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
s_axis_tdata  in  S_COUNT*DATA_WIDTH  input data; stream i at [i*DATA_WIDTH +: DATA_WIDTH]
s_axis_tkeep  in  S_COUNT*KEEP_WIDTH  input keep
s_axis_tvalid  in  S_COUNT  per-input valid
s_axis_tready  out  S_COUNT  per-input ready
s_axis_tlast  in  S_COUNT  per-input last
s_axis_tuser  in  S_COUNT*USER_WIDTH  input user
m_axis_tdata  out  DATA_WIDTH  output data
m_axis_tkeep  out  KEEP_WIDTH  output keep; all ones if !KEEP_ENABLE
m_axis_tvalid  out  1  output valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  output last; 1 if !LAST_ENABLE
m_axis_tuser  out  USER_WIDTH  output user; 0 if !USER_ENABLE
grant_valid  out  1  a frame is currently granted
grant_index  out  CL_S_COUNT  index of granted input (valid when grant_valid)

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; grant_valid=0; grant_index=0; s_axis_tready=0; m_axis_tvalid=0; last_grant pointer=S_COUNT-1, so input 0 has highest priority first. Output data registers are not reset.
- States: IDLE, XFER.
- IDLE, no tvalid asserted: stay in IDLE.
- IDLE, any s_axis_tvalid asserted: pick the first asserting index scanning last_grant+1, last_grant+2, ... modulo S_COUNT. Register it into grant_index, set grant_valid=1 and last_grant=index, go to XFER. The grant is visible the next cycle; there is no combinational request-to-ready path.
- XFER:
  - s_axis_tready[grant_index] = (m_axis_tready || !m_axis_tvalid).
  - All other tready bits are 0. All tready bits are 0 in IDLE.
- Beat accept: tvalid && tready on the granted input. The beat is loaded into the output register and m_axis_tvalid=1 the next cycle. Latency from input accept to output is exactly 1 cycle. Throughput is 1 beat/cycle within a frame.
- Output register:
  - If m_axis_tready && m_axis_tvalid with no new accept, m_axis_tvalid goes to 0.
  - Simultaneous drain and accept: new beat replaces old, m_axis_tvalid stays 1.
  - Output contents are stable while m_axis_tvalid && !m_axis_tready.
- Frame end: an accepted beat with tlast=1, or any accepted beat when !LAST_ENABLE. grant_valid goes to 0 and state goes to IDLE in the following cycle.
- Minimum one idle (arbitration) cycle between frames. A back-to-back frame from the same or another input starts no earlier than 2 cycles after the previous tlast accept.
- Granted input drops tvalid mid-frame: the grant is held indefinitely, with no switch and no timeout.
- Non-granted inputs asserting tvalid: they wait; tready stays 0; their data is ignored.
- Fairness: with all inputs continuously requesting, grants rotate 0,1,...,S_COUNT-1,0,...
- A single requester may be re-granted consecutively when no other input requests.
- Reset mid-frame: the frame is abandoned. Beats not yet accepted are never output. Any beat held in the output register is dropped (m_axis_tvalid=0). No partial-frame recovery is performed.
- Pointer arithmetic wraps modulo S_COUNT, including non-power-of-2 S_COUNT (index S_COUNT-1 wraps to 0).

Test Plan:
- Reset then all idle -> grant_valid=0, all tready=0, m_axis_tvalid=0 for 10 cycles.
- S_COUNT=4, input 2 sends a 3-beat frame 0xA1,0xA2,0xA3(last), m_axis_tready=1 -> grant_index=2 one cycle after tvalid; output beats on 3 consecutive cycles, each 1 cycle after accept; grant_valid=0 the cycle after the last accept.
- All 4 inputs each continuously offer 2-beat frames -> output frame order 0,1,2,3,0,1; no interleaving; tlast on every 2nd beat.
- Backpressure: m_axis_tready toggles 1,0,0,1 during a 4-beat frame from input 1 -> output data held stable while stalled; no beat lost or duplicated; exactly 4 output handshakes.
- Input 3 mid-frame drops tvalid for 5 cycles while input 0 requests -> grant stays 3; input 0 tready=0 until input 3 tlast is accepted; input 0 granted next.
- Assert rst_n=0 for 1 cycle during beat 2 of a 4-beat frame -> next cycle grant_valid=0, m_axis_tvalid=0; a following request from input 0 is granted first.
